// File: rtl/pipe_adder_if.sv
// pipe_adder_if -- operand/result handshake bundle for pipe_adder.
// The master side presents operands and accepts results; the slave side
// (the adder) consumes operands and produces results.
interface pipe_adder_if #(
    parameter int WIDTH = 32
);
    // Operand channel
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;

    // Result channel
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );
endinterface

// File: rtl/pipe_adder.sv
// pipe_adder -- pipelined ripple-by-slice adder/subtractor.
// Stage k resolves bit slice k (WIDTH/STAGES bits) using the registered carry
// of stage k-1; the not-yet-added upper operand slices travel with the data.
// The last stage register is the output register, so a result appears
// STAGES cycles after acceptance. A stalled output freezes the whole pipe.
// Optional build macro: PIPE_ADDER_SAT_EN clamps the sum on signed overflow.
module pipe_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input logic         clk,
    input logic         rst_n,
    pipe_adder_if.slave bus
);
    localparam int SW  = WIDTH / STAGES;
    localparam int LST = STAGES - 1;
    localparam int MSB = WIDTH - 1;

    // Per-stage pipeline state; index k is the register after stage k.
    logic [STAGES-1:0] vld_q, vld_d;
    logic [STAGES-1:0] c_q, c_d;
    logic [WIDTH-1:0]  a_q  [STAGES];
    logic [WIDTH-1:0]  a_d  [STAGES];
    logic [WIDTH-1:0]  bx_q [STAGES];
    logic [WIDTH-1:0]  bx_d [STAGES];
    logic [WIDTH-1:0]  s_q  [STAGES];
    logic [WIDTH-1:0]  s_d  [STAGES];
    logic              ovf_q, ovf_d;
    logic              zero_q, zero_d;

    logic [SW:0]       part [STAGES];
    logic [WIDTH-1:0]  bx_in;
    logic [WIDTH-1:0]  raw_sum;
    logic              adv;
    logic              in_ready;
    logic              accept;

    // One slice of the carry chain: {carry_out, slice_sum}.
    function automatic logic [SW:0] slice_add(
        input logic [SW-1:0] x,
        input logic [SW-1:0] y,
        input logic          cin
    );
        return {1'b0, x} + {1'b0, y} + {{SW{1'b0}}, cin};
    endfunction

    // Signed overflow: operands agree in sign but the result does not.
    function automatic logic sum_ovf(
        input logic signed [WIDTH-1:0] x,
        input logic signed [WIDTH-1:0] y,
        input logic signed [WIDTH-1:0] r
    );
        return ((x < 0) == (y < 0)) && ((r < 0) != (x < 0));
    endfunction

`ifdef PIPE_ADDER_SAT_EN
    // Clamp to the most positive / most negative value on overflow; the
    // overflow direction follows the sign shared by both operands.
    function automatic logic signed [WIDTH-1:0] saturate(
        input logic signed [WIDTH-1:0] r,
        input logic                    ov,
        input logic                    neg
    );
        if (!ov)
            return r;
        return neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    endfunction
`endif

    // The pipe moves unless a valid result is being held back downstream.
    assign adv      = !(vld_q[LST] && !bus.out_ready);
    assign in_ready = rst_n && adv;
    assign accept   = bus.in_valid && in_ready;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = vld_q[LST];
    assign bus.sum       = s_q[LST];
    assign bus.cout      = c_q[LST];
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;

    // Next-state for every stage: add one slice, shift the rest along.
    always_comb begin
        bx_in   = bus.sub ? ~bus.b : bus.b;
        vld_d   = '0;
        c_d     = '0;
        raw_sum = '0;

        // Stage 0: slice 0 straight from the ports, carry-in = sub.
        part[0]            = slice_add(bus.a[SW-1:0], bx_in[SW-1:0], bus.sub);
        a_d[0]             = bus.a;
        bx_d[0]            = bx_in;
        s_d[0]             = '0;
        s_d[0][SW-1:0]     = part[0][SW-1:0];
        c_d[0]             = part[0][SW];
        vld_d[0]           = accept;

        // Stages 1..STAGES-1: continue from the previous stage register.
        for (int k = 1; k < STAGES; k++) begin
            part[k]            = slice_add(a_q[k-1][k*SW +: SW],
                                           bx_q[k-1][k*SW +: SW],
                                           c_q[k-1]);
            a_d[k]             = a_q[k-1];
            bx_d[k]            = bx_q[k-1];
            s_d[k]             = s_q[k-1];
            s_d[k][k*SW +: SW] = part[k][SW-1:0];
            c_d[k]             = part[k][SW];
            vld_d[k]           = vld_q[k-1];
        end

        // Final stage: flags from the unclamped sum, then optional clamp.
        raw_sum = s_d[LST];
        ovf_d   = sum_ovf(a_d[LST], bx_d[LST], raw_sum);
`ifdef PIPE_ADDER_SAT_EN
        s_d[LST] = saturate(raw_sum, ovf_d, a_d[LST][MSB]);
`endif
        zero_d  = (s_d[LST] == '0);
    end

    // Valid bits and result flags: cleared by reset, frozen on stall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q  <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (adv) begin
            vld_q  <= vld_d;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    // Datapath registers: only the output stage is cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_q[LST] <= '0;
            c_q[LST] <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]  <= a_d[k];
                bx_q[k] <= bx_d[k];
                s_q[k]  <= s_d[k];
            end
            c_q <= c_d;
        end
    end
endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder -- directed and random checks of pipe_adder against an
// arithmetic reference model with a FIFO scoreboard.
module tb_pipe_adder;
    localparam int W = 32;
    localparam int S = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pipe_adder_if #(.WIDTH(W)) bus ();
    pipe_adder #(.WIDTH(W), .STAGES(S)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
        int           acc_cyc;
        int           acc_stalls;
    } exp_t;

    exp_t         q[$];
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           stall_cnt = 0;
    logic         stalled_prev = 1'b0;
    logic         accepted;
    logic [W-1:0] held_sum;
    logic [2:0]   held_flags;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        exp_t   e;
        longint sx, sy, ux, uy, r;
        sx = $signed(x);
        sy = $signed(y);
        ux = x;
        uy = y;
        r  = s ? sx - sy : sx + sy;
        e.ovf  = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        e.cout = s ? (ux >= uy) : ((ux + uy) >= 64'sh100000000);
        e.sum  = r[W-1:0];
`ifdef PIPE_ADDER_SAT_EN
        if (e.ovf) e.sum = (r > 0) ? 32'h7FFFFFFF : 32'h80000000;
`endif
        e.zero       = (e.sum == '0);
        e.acc_cyc    = 0;
        e.acc_stalls = 0;
        return e;
    endfunction

    // One clock cycle: drive, check handshake/results, advance.
    task automatic tick(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic isub, input logic ordy, input logic rn);
        exp_t e;
        int   lat;
        bus.in_valid  = iv;
        bus.a         = ia;
        bus.b         = ib;
        bus.sub       = isub;
        bus.out_ready = ordy;
        rst_n         = rn;
        #1;
        chk("in_ready", bus.in_ready, rn && !(bus.out_valid && !ordy));
        if (stalled_prev) begin
            chk("stall_valid", bus.out_valid, 1'b1);
            chk("stall_sum", bus.sum, held_sum);
            chk("stall_flags", {bus.cout, bus.ovf, bus.zero}, held_flags);
        end
        if (rn && bus.out_valid)
            chk("spurious_result", q.size() > 0, 1'b1);
        if (rn && bus.out_valid && ordy && q.size() > 0) begin
            e = q.pop_front();
            lat = e.acc_cyc + S + (stall_cnt - e.acc_stalls);
            chk("sum", bus.sum, e.sum);
            chk("cout", bus.cout, e.cout);
            chk("ovf", bus.ovf, e.ovf);
            chk("zero", bus.zero, e.zero);
            chk("latency", cyc, lat);
        end
        accepted = rn && iv && bus.in_ready;
        if (accepted) begin
            e = model(ia, ib, isub);
            e.acc_cyc    = cyc;
            e.acc_stalls = stall_cnt;
            q.push_back(e);
        end
        stalled_prev = rn && bus.out_valid && !ordy;
        if (stalled_prev) begin
            stall_cnt++;
            held_sum   = bus.sum;
            held_flags = {bus.cout, bus.ovf, bus.zero};
        end
        if (!rn) q.delete();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic idle(input logic ordy);
        tick(1'b0, $urandom, $urandom, 1'b0, ordy, 1'b1);
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && q.size() != 0; k++) idle(1'b1);
        chk("drain_left", q.size(), 0);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'h7FFFFFFF;
            3: return 32'h80000000;
            4: return 32'hFFFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        // Reset
        for (int k = 0; k < 3; k++) tick(1'b1, 32'h1, 32'h1, 1'b0, 1'b1, 1'b0);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_sum", bus.sum, 32'h0);
        chk("rst_cout", bus.cout, 1'b0);
        chk("rst_ovf", bus.ovf, 1'b0);
        chk("rst_zero", bus.zero, 1'b0);
        chk("rst_in_ready", bus.in_ready, 1'b0);

        // Carry wrap to zero
        tick(1'b1, 32'hFFFFFFFF, 32'h1, 1'b0, 1'b1, 1'b1);
        chk("first_accept", accepted, 1'b1);
        drain();
        // Positive overflow
        tick(1'b1, 32'h7FFFFFFF, 32'h1, 1'b0, 1'b1, 1'b1);
        drain();
        // Subtraction with and without borrow, back to back
        tick(1'b1, 32'h5, 32'h7, 1'b1, 1'b1, 1'b1);
        tick(1'b1, 32'h7, 32'h5, 1'b1, 1'b1, 1'b1);
        drain();

        // Eight back-to-back ops with out_ready low on cycles 5..7
        begin
            int i = 0;
            for (int j = 0; j < 40 && i < 8; j++) begin
                tick(1'b1, i, i, 1'b0, !(j >= 5 && j <= 7), 1'b1);
                if (accepted) i++;
            end
            chk("b2b_issued", i, 8);
        end
        drain();

        // Random traffic with random backpressure
        for (int k = 0; k < 400; k++)
            tick($urandom_range(0, 3) != 0, pick(), pick(), $urandom_range(0, 1),
                 $urandom_range(0, 9) < 7, 1'b1);
        drain();

        // Reset with ops in flight during a stall
        for (int k = 0; k < 3; k++) tick(1'b1, 32'h10 + k, 32'h3, 1'b0, 1'b0, 1'b1);
        idle(1'b0);
        idle(1'b0);
        chk("pre_rst_stalled", bus.out_valid, 1'b1);
        tick(1'b1, 32'h99, 32'h1, 1'b0, 1'b0, 1'b0);
        chk("post_rst_out_valid", bus.out_valid, 1'b0);
        for (int k = 0; k < 10; k++) idle(1'b1);
        chk("post_rst_quiet", bus.out_valid, 1'b0);

        // Recovery after reset
        tick(1'b1, 32'h80000000, 32'h1, 1'b1, 1'b1, 1'b1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_adder.md
PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits; SHALL be a multiple of STAGES.
REQ-002 Parameter: STAGES, 4, pipeline depth; each stage resolves WIDTH/STAGES bits of the carry chain; legal range 1..WIDTH.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port: in_valid  input  1  operand set a/b/sub presented.
REQ-006 Port: in_ready  output  1  block accepts operands this cycle.
REQ-007 Port: a, b  input  WIDTH each  operands, two's complement or unsigned.
REQ-008 Port: sub  input  1  0 = a+b, 1 = a-b.
REQ-009 Port: out_valid  output  1  result registers hold a valid result.
REQ-010 Port: out_ready  input  1  downstream accepts result this cycle.
REQ-011 Port: sum  output  WIDTH  result.
REQ-012 Port: cout  output  1  carry out of MSB (sub: 1 = no borrow).
REQ-013 Port: ovf  output  1  signed overflow.
REQ-014 Port: zero  output  1  sum == 0.

Function
REQ-015 Transfer occurs on a handshake side iff valid && ready in the same cycle; no other condition moves data.
REQ-016 Subtraction SHALL be computed as a + ~b + 1 (carry-in = sub); cout is the raw MSB carry in both modes.
REQ-017 Stage k SHALL add bit slice k using the registered carry of stage k-1; unresolved upper operand slices travel with the pipeline.
REQ-018 Latency: accepted operands SHALL appear at out_valid exactly STAGES cycles after acceptance when out_ready is held 1.
REQ-019 Throughput: one operation per cycle with out_ready held 1; in_ready SHALL be combinationally 1 in that case.
REQ-020 Stall: when out_valid=1 and out_ready=0 the whole pipeline SHALL freeze; in_ready=0; sum/cout/ovf/zero/out_valid stable.
REQ-021 Bubbles: empty stages SHALL carry valid=0; a bubble does not count toward acceptance, and in_ready depends only on REQ-020.
REQ-022 Ordering: results SHALL emerge in acceptance order; none dropped or duplicated under any stall pattern.
REQ-023 ovf = (a[MSB] == b'[MSB]) && (sum[MSB] != a[MSB]), b' = b or ~b per sub.
REQ-024 zero SHALL reflect the output sum (post-saturation when REQ-029 applies).
REQ-025 Sum SHALL wrap modulo 2^WIDTH (non-saturating build).

Reset
REQ-026 With rst_n=0 at a clock edge all stage valid bits, out_valid, sum, cout, ovf, zero SHALL clear to 0; in-flight operations are discarded.
REQ-027 During reset in_ready SHALL be 0; first acceptance possible on the first edge with rst_n=1.
REQ-028 Reset asserted mid-stall SHALL override the stall; no result from before reset appears afterwards.

Configuration
REQ-029 Macro PIPE_ADDER_SAT_EN defined: on ovf=1, sum SHALL clamp to 0x7F..F (positive overflow) or 0x80..0 (negative overflow); ovf and cout still report the unclamped event.
REQ-030 Macro PIPE_ADDER_SAT_EN undefined: sum wraps per REQ-025; no clamp logic present.

Verification (WIDTH=32, STAGES=4)
REQ-031 a=0xFFFFFFFF, b=1, sub=0, out_ready=1 -> 4 cycles later sum=0, cout=1, zero=1, ovf=0.
REQ-032 a=0x7FFFFFFF, b=1, sub=0 -> ovf=1, cout=0; sum=0x80000000 (no SAT), 0x7FFFFFFF (SAT_EN).
REQ-033 a=5, b=7, sub=1 -> sum=0xFFFFFFFE, cout=0, ovf=0; a=7, b=5, sub=1 -> sum=2, cout=1.
REQ-034 8 back-to-back ops (a=i, b=i, i=0..7), out_ready low cycles 5-7 -> in_ready low while stalled, outputs 0,2,..,14 in order, none lost.
REQ-035 rst_n low one cycle with 3 ops in flight and out_ready=0 -> out_valid=0 next cycle, no stale result ever emerges.
